// File: rtl/ym_phase_slot_seq.sv
// Slot/phase timing sequencer: splits MCLK into non-overlapping c1/c2 enables,
// counts slots and frames, and emits the debug-chain load strobe and resync.
module ym_phase_slot_seq #(
  parameter int PRESCALE    = 6,
  parameter int SLOT_COUNT  = 24,
  parameter int SLOT_WIDTH  = 5,
  parameter int FRAME_WIDTH = 8
) (
  input  logic                   MCLK,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   resync,
  output logic                   c1,
  output logic                   c2,
  output logic [SLOT_WIDTH-1:0]  slot,
  output logic [FRAME_WIDTH-1:0] frame,
  output logic                   slot_zero,
  output logic                   dbg_load,
  output logic                   resync_pend
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]         P_LAST    = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]         P_HALF    = PW'(PRESCALE / 2);
  localparam logic [SLOT_WIDTH-1:0] SLOT_LAST = SLOT_WIDTH'(SLOT_COUNT - 1);

  logic [PW-1:0]          pcnt_q, pcnt_d;
  logic                   c1_q, c1_d;
  logic                   c2_q, c2_d;
  logic [SLOT_WIDTH-1:0]  slot_q, slot_d;
  logic [FRAME_WIDTH-1:0] frame_q, frame_d;
  logic                   sz_q, sz_d;
  logic                   dbg_q, dbg_d;
  logic                   pend_q, pend_d;
  logic                   boundary;
  logic                   go;

  // A boundary only exists on an enabled edge; a frozen pcnt at P_LAST is not one.
  assign boundary = en && (pcnt_q == P_LAST);
  assign go       = resync | pend_q;

  always_comb begin
    pcnt_d  = pcnt_q;
    c1_d    = 1'b0;
    c2_d    = 1'b0;
    dbg_d   = 1'b0;
    slot_d  = slot_q;
    frame_d = frame_q;
    pend_d  = pend_q | resync;

    if (en) begin
      pcnt_d = boundary ? '0 : pcnt_q + PW'(1);
      c1_d   = (pcnt_q == '0);
      c2_d   = (pcnt_q == P_HALF);
      dbg_d  = (pcnt_q == '0) && (slot_q == '0);
    end

    if (boundary) begin
      pend_d = 1'b0;
      if (go) begin
        slot_d  = '0;
        frame_d = '0;
      end else if (slot_q == SLOT_LAST) begin
        slot_d  = '0;
        frame_d = frame_q + FRAME_WIDTH'(1);
      end else begin
        slot_d  = slot_q + SLOT_WIDTH'(1);
      end
    end

    sz_d = (slot_d == '0);
  end

  always_ff @(posedge MCLK) begin
    if (!rst) begin
      pcnt_q  <= '0;
      c1_q    <= 1'b0;
      c2_q    <= 1'b0;
      slot_q  <= '0;
      frame_q <= '0;
      sz_q    <= 1'b1;
      dbg_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      slot_q  <= slot_d;
      frame_q <= frame_d;
      sz_q    <= sz_d;
      dbg_q   <= dbg_d;
      pend_q  <= pend_d;
    end
  end

  assign c1          = c1_q;
  assign c2          = c2_q;
  assign slot        = slot_q;
  assign frame       = frame_q;
  assign slot_zero   = sz_q;
  assign dbg_load    = dbg_q;
  assign resync_pend = pend_q;

endmodule

// File: tb/tb_ym_phase_slot_seq.sv
// Directed bench for ym_phase_slot_seq: the driver queues hand-computed output
// vectors tagged with the cycle they belong to; a negedge monitor checks them.
`timescale 1ns/1ps
module tb_ym_phase_slot_seq;

  localparam int W = 18;

  logic       MCLK = 1'b0;
  logic       rst;
  logic       en;
  logic       resync;
  logic       c1, c2, slot_zero, dbg_load, resync_pend;
  logic [4:0] slot;
  logic [7:0] frame;

  ym_phase_slot_seq #(
    .PRESCALE(6), .SLOT_COUNT(24), .SLOT_WIDTH(5), .FRAME_WIDTH(8)
  ) dut (
    .MCLK(MCLK), .rst(rst), .en(en), .resync(resync),
    .c1(c1), .c2(c2), .slot(slot), .frame(frame),
    .slot_zero(slot_zero), .dbg_load(dbg_load), .resync_pend(resync_pend)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 MCLK = ~MCLK;

  int cyc = 0;
  always @(posedge MCLK) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           cyc_q[$];
  string        name_q[$];
  int           n_cmp  = 0;
  int           n_fail = 0;
  int           base   = 0;
  logic [W-1:0] obs;

  localparam logic [W-1:0] RST_VEC = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'd0};

  // Packing: {c1, c2, dbg_load, slot_zero, resync_pend, slot, frame}
  function automatic logic [W-1:0] v(input logic c1e, input logic c2e, input logic dbe,
                                     input logic sze, input logic pe, input int s, input int f);
    return {c1e, c2e, dbe, sze, pe, 5'(s), 8'(f)};
  endfunction

  task automatic push_abs(input int c, input string nm, input logic [W-1:0] e);
    cyc_q.push_back(c);
    name_q.push_back(nm);
    exp_q.push_back(e);
  endtask

  // k is the edge number counted from the first edge after reset release.
  task automatic expect_at(input int k, input string nm, input logic [W-1:0] e);
    push_abs(base + k, nm, e);
  endtask

  always @(negedge MCLK) begin
    obs = {c1, c2, dbg_load, slot_zero, resync_pend, slot, frame};
    if (rst === 1'b1) begin
      n_cmp++;
      if (c1 && c2) begin
        n_fail++;
        $display("FAIL phase_overlap @cyc %0d: got c1=%b c2=%b, expected never both high", cyc, c1, c2);
      end
    end
    while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
      n_cmp++;
      if (cyc_q[0] < cyc) begin
        n_fail++;
        $display("FAIL %s: check for cyc %0d never sampled (now %0d)", name_q[0], cyc_q[0], cyc);
      end else if (obs !== exp_q[0]) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got {c1,c2,dbg,sz,pend,slot,frame}=%b_%b_%b_%b_%b_%0d_%0d expected %b_%b_%b_%b_%b_%0d_%0d",
                 name_q[0], cyc, obs[17], obs[16], obs[15], obs[14], obs[13], obs[12:8], obs[7:0],
                 exp_q[0][17], exp_q[0][16], exp_q[0][15], exp_q[0][14], exp_q[0][13],
                 exp_q[0][12:8], exp_q[0][7:0]);
      end
      void'(cyc_q.pop_front());
      void'(name_q.pop_front());
      void'(exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  // Return with inputs settable for edge k (i.e. just after edge k-1).
  task automatic at_edge(input int k);
    while (cyc < base + k - 1) begin
      @(posedge MCLK);
      #1;
    end
  endtask

  task automatic run_to(input int k);
    while (cyc < base + k) begin
      @(posedge MCLK);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    @(posedge MCLK); #1;
    @(posedge MCLK); #1;
    push_abs(cyc, "reset_vals", RST_VEC);
    rst  = 1'b1;
    base = cyc + 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; en = 1'b1; resync = 1'b0;

    // Scenario A: release, first slots, full frame wrap
    apply_reset();
    expect_at(0,   "a_e0_c1_dbg",   v(1, 0, 1, 1, 0, 0, 0));
    expect_at(1,   "a_e1_idle",     v(0, 0, 0, 1, 0, 0, 0));
    expect_at(3,   "a_e3_c2",       v(0, 1, 0, 1, 0, 0, 0));
    expect_at(5,   "a_e5_slot1",    v(0, 0, 0, 0, 0, 1, 0));
    expect_at(6,   "a_e6_c1_nodbg", v(1, 0, 0, 0, 0, 1, 0));
    expect_at(9,   "a_e9_c2",       v(0, 1, 0, 0, 0, 1, 0));
    expect_at(12,  "a_e12_c1",      v(1, 0, 0, 0, 0, 2, 0));
    expect_at(15,  "a_e15_c2",      v(0, 1, 0, 0, 0, 2, 0));
    expect_at(137, "a_e137_slot23", v(0, 0, 0, 0, 0, 23, 0));
    expect_at(138, "a_e138_c1",     v(1, 0, 0, 0, 0, 23, 0));
    expect_at(143, "a_e143_wrap",   v(0, 0, 0, 1, 0, 0, 1));
    expect_at(144, "a_e144_dbg",    v(1, 0, 1, 1, 0, 0, 1));
    run_to(145);

    // Scenario B: resync mid-slot, at boundary, merged; then en freeze
    apply_reset();
    expect_at(39, "b_e39_c2",        v(0, 1, 0, 0, 0, 6, 0));
    expect_at(40, "b_e40_pend",      v(0, 0, 0, 0, 1, 6, 0));
    expect_at(41, "b_e41_apply",     v(0, 0, 0, 1, 0, 0, 0));
    expect_at(42, "b_e42_dbg",       v(1, 0, 1, 1, 0, 0, 0));
    expect_at(45, "b_e45_c2",        v(0, 1, 0, 1, 0, 0, 0));
    expect_at(46, "b_e46_nopend",    v(0, 0, 0, 1, 0, 0, 0));
    expect_at(47, "b_e47_bnd_rs",    v(0, 0, 0, 1, 0, 0, 0));
    expect_at(48, "b_e48_dbg",       v(1, 0, 1, 1, 0, 0, 0));
    expect_at(50, "b_e50_pend",      v(0, 0, 0, 1, 1, 0, 0));
    expect_at(51, "b_e51_merge",     v(0, 1, 0, 1, 1, 0, 0));
    expect_at(52, "b_e52_pend",      v(0, 0, 0, 1, 1, 0, 0));
    expect_at(53, "b_e53_apply",     v(0, 0, 0, 1, 0, 0, 0));
    expect_at(54, "b_e54_dbg",       v(1, 0, 1, 1, 0, 0, 0));
    expect_at(59, "b_e59_slot1",     v(0, 0, 0, 0, 0, 1, 0));
    expect_at(60, "b_e60_c1",        v(1, 0, 0, 0, 0, 1, 0));
    expect_at(61, "b_e61_pcnt2",     v(0, 0, 0, 0, 0, 1, 0));
    expect_at(62, "b_e62_frozen",    v(0, 0, 0, 0, 0, 1, 0));
    expect_at(66, "b_e66_frozen",    v(0, 0, 0, 0, 0, 1, 0));
    expect_at(71, "b_e71_frozen",    v(0, 0, 0, 0, 0, 1, 0));
    expect_at(72, "b_e72_resume",    v(0, 0, 0, 0, 0, 1, 0));
    expect_at(73, "b_e73_c2",        v(0, 1, 0, 0, 0, 1, 0));
    expect_at(75, "b_e75_slot2",     v(0, 0, 0, 0, 0, 2, 0));
    expect_at(76, "b_e76_c1",        v(1, 0, 0, 0, 0, 2, 0));
    expect_at(79, "b_e79_c2",        v(0, 1, 0, 0, 0, 2, 0));
    expect_at(81, "b_e81_slot3",     v(0, 0, 0, 0, 0, 3, 0));
    expect_at(82, "b_e82_c1",        v(1, 0, 0, 0, 0, 3, 0));
    at_edge(40); resync = 1'b1;
    at_edge(41); resync = 1'b0;
    at_edge(47); resync = 1'b1;
    at_edge(48); resync = 1'b0;
    at_edge(50); resync = 1'b1;
    at_edge(52); resync = 1'b0;
    at_edge(62); en = 1'b0;
    at_edge(72); en = 1'b1;
    run_to(82);

    // Scenario C: reset while slot=10, frame=3, resync pending
    apply_reset();
    expect_at(493, "c_e493_pend",  v(0, 0, 0, 0, 1, 10, 3));
    expect_at(494, "c_e494_state", v(0, 0, 0, 0, 1, 10, 3));
    at_edge(493); resync = 1'b1;
    at_edge(494); resync = 1'b0;
    at_edge(495); rst = 1'b0;
    @(posedge MCLK); #1;
    push_abs(cyc, "c_mid_reset", RST_VEC);
    rst  = 1'b1;
    base = cyc + 1;
    expect_at(0, "c_r0_c1_dbg", v(1, 0, 1, 1, 0, 0, 0));
    expect_at(3, "c_r3_c2",     v(0, 1, 0, 1, 0, 0, 0));
    expect_at(5, "c_r5_slot1",  v(0, 0, 0, 0, 0, 1, 0));
    expect_at(6, "c_r6_c1",     v(1, 0, 0, 0, 0, 1, 0));
    run_to(8);

    @(negedge MCLK); #1;
    if (cyc_q.size() != 0) begin
      n_fail += cyc_q.size();
      $display("FAIL leftover: %0d checks never sampled, expected 0", cyc_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
